// File: rtl/delay_ctrl.sv
// Sequencing controller for the mic-sample delay line: turns sample ticks and
// start/stop/offset commands into registered en/wr/rd pulses and the active offset.
module delay_ctrl #(
  parameter int ADDRESS_WIDTH  = 9,
  parameter int DEFAULT_OFFSET = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     offset_load,
  input  logic [ADDRESS_WIDTH-1:0] offset_req,
  output logic                     en,
  output logic                     wr,
  output logic                     rd,
  output logic [ADDRESS_WIDTH-1:0] offset,
  output logic                     out_valid,
  output logic [1:0]               state
);

  localparam int AW = ADDRESS_WIDTH;
  localparam logic [AW-1:0] DEF_OFFSET = AW'(DEFAULT_OFFSET);
  localparam logic [AW-1:0] ONE        = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PRIME = 2'b01,
    S_RUN   = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t        state_q;
  logic [AW-1:0] offset_q;
  logic [AW-1:0] prime_cnt_q;
  logic [AW-1:0] drain_cnt_q;
  logic [AW-1:0] pend_q;
  logic          pend_vld_q;
  logic          en_q, wr_q, rd_q, out_valid_q;
  logic [AW-1:0] req_clamp_d;

  // A zero delay is meaningless for the RAM, so it is promoted to one sample.
  assign req_clamp_d = (offset_req == '0) ? ONE : offset_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      offset_q    <= DEF_OFFSET;
      prime_cnt_q <= '0;
      drain_cnt_q <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      out_valid_q <= rd_q;
      case (state_q)
        S_IDLE: begin
          if (offset_load) offset_q <= req_clamp_d;
          if (start) begin
            state_q     <= S_PRIME;
            prime_cnt_q <= offset_load ? req_clamp_d : offset_q;
          end
        end
        S_PRIME: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (sample_tick) begin
            en_q        <= 1'b1;
            wr_q        <= 1'b1;
            prime_cnt_q <= prime_cnt_q - ONE;
            if (prime_cnt_q == ONE) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            if (sample_tick) begin
              en_q <= 1'b1;
              wr_q <= 1'b1;
              rd_q <= 1'b1;
            end
            state_q     <= S_DRAIN;
            drain_cnt_q <= offset_q;
            pend_vld_q  <= 1'b0;
          end else begin
            if (sample_tick) begin
              en_q <= 1'b1;
              wr_q <= 1'b1;
              rd_q <= 1'b1;
              // Pending offset takes effect here; growth needs the extra samples written first.
              if (pend_vld_q) begin
                pend_vld_q <= 1'b0;
                offset_q   <= pend_q;
                if (pend_q > offset_q) begin
                  state_q     <= S_PRIME;
                  prime_cnt_q <= pend_q - offset_q;
                end
              end
            end
            if (offset_load) begin
              pend_q     <= req_clamp_d;
              pend_vld_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (sample_tick) begin
            en_q        <= 1'b1;
            rd_q        <= 1'b1;
            drain_cnt_q <= drain_cnt_q - ONE;
            if (drain_cnt_q == ONE) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign en        = en_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign out_valid = out_valid_q;
  assign offset    = offset_q;
  assign state     = state_q;

endmodule

// File: tb/tb_delay_ctrl.sv
// Scoreboard bench for delay_ctrl: stimulus queues the expected pulse per tick,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_delay_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick, start, stop, offset_load;
  logic [8:0] offset_req;
  logic       en, wr, rd, out_valid;
  logic [8:0] offset;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  int         ov_q[$];
  logic       prev_rd = 1'b0;

  localparam int NONE = 0, WR = 1, WRRD = 2, RDO = 3;

  delay_ctrl #(.ADDRESS_WIDTH(9), .DEFAULT_OFFSET(64)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .start(start), .stop(stop),
    .offset_load(offset_load), .offset_req(offset_req), .en(en), .wr(wr), .rd(rd),
    .offset(offset), .out_valid(out_valid), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expected pulse (if any) is queued for the monitor.
  task automatic step(input logic t, input logic s, input logic p, input logic l,
                      input int req, input int exp);
    sample_tick = t; start = s; stop = p; offset_load = l; offset_req = 9'(req);
    case (exp)
      WR:   exp_q.push_back(2'b10);
      WRRD: begin exp_q.push_back(2'b11); ov_q.push_back(1); end
      RDO:  begin exp_q.push_back(2'b01); ov_q.push_back(1); end
      default: ;
    endcase
    @(posedge clk); #1;
    sample_tick = 0; start = 0; stop = 0; offset_load = 0; offset_req = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, NONE);
  endtask

  // Tick followed by two idle cycles (tick every 3 cycles).
  task automatic tick3(input int exp);
    step(1, 0, 0, 0, 0, exp);
    idle(2);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got wr=%0b rd=%0b expected none at %0t", wr, rd, $time);
        end else begin
          chk("pulse_wr_rd", int'({wr, rd}), int'(exp_q.pop_front()));
        end
      end else if (wr || rd) begin
        checks++; errors++;
        $display("FAIL stray_wr_rd: got wr=%0b rd=%0b expected 0 (en low) at %0t", wr, rd, $time);
      end
      if (out_valid || prev_rd) chk("out_valid_latency", int'(out_valid), int'(prev_rd));
      if (out_valid) begin
        if (ov_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
        end else begin
          void'(ov_q.pop_front());
        end
      end
      prev_rd = rd;
    end else begin
      prev_rd = 1'b0;
    end
  end

  initial begin
    rst = 1'b1;
    sample_tick = 0; start = 0; stop = 0; offset_load = 0; offset_req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_offset", offset, 64);
    chk("reset_outputs", int'({en, wr, rd, out_valid}), 0);
    rst = 1'b0;
    idle(1);

    // Prime at offset 4
    step(1, 0, 0, 0, 0, NONE);
    step(0, 0, 0, 1, 4, NONE);
    chk("idle_load_offset", offset, 4);
    step(0, 1, 0, 0, 0, NONE);
    chk("start_prime", state, 1);
    tick3(WR); tick3(WR); tick3(WR);
    chk("prime_not_done", state, 1);
    tick3(WR);
    chk("prime_to_run", state, 2);
    tick3(WRRD);
    tick3(WRRD);

    // Grow 4 -> 6: applies at next tick, two write-only refill pulses
    step(0, 0, 0, 1, 6, NONE);
    chk("grow_pending_offset", offset, 4);
    chk("grow_pending_state", state, 2);
    tick3(WRRD);
    chk("grow_offset", offset, 6);
    chk("grow_state", state, 1);
    tick3(WR); tick3(WR);
    chk("grow_back_run", state, 2);
    tick3(WRRD);

    // Shrink with clamp: load 0 -> 1, no read gap; tick in load cycle keeps old offset
    step(1, 0, 0, 1, 0, WRRD);
    chk("load_tick_old_offset", offset, 6);
    idle(1);
    tick3(WRRD);
    chk("clamp_offset", offset, 1);
    chk("shrink_state", state, 2);
    tick3(WRRD);

    // Grow 1 -> 3 then drain 3
    step(0, 0, 0, 1, 3, NONE);
    tick3(WRRD);
    chk("grow3_offset", offset, 3);
    tick3(WR); tick3(WR);
    tick3(WRRD);
    chk("run_before_stop", state, 2);
    step(0, 0, 1, 0, 0, NONE);
    chk("stop_drain", state, 3);
    step(0, 1, 0, 0, 0, NONE);
    chk("drain_ignore_start", state, 3);
    tick3(RDO); tick3(RDO);
    chk("drain_not_done", state, 3);
    tick3(RDO);
    chk("drain_to_idle", state, 0);
    tick3(NONE);

    // Stop + load collision: stop wins, old offset kept
    step(0, 1, 0, 0, 0, NONE);
    tick3(WR); tick3(WR); tick3(WR);
    chk("coll_run", state, 2);
    step(0, 0, 1, 1, 7, NONE);
    chk("coll_state", state, 3);
    chk("coll_offset", offset, 3);
    tick3(RDO); tick3(RDO); tick3(RDO);
    chk("coll_idle", state, 0);
    chk("coll_offset_after", offset, 3);

    // Back-to-back ticks across the address wrap
    step(0, 1, 0, 0, 0, NONE);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, WR);
    for (int i = 0; i < 600; i++) step(1, 0, 0, 0, 0, WRRD);
    step(0, 0, 1, 0, 0, NONE);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, RDO);
    chk("b2b_idle", state, 0);
    idle(3);

    // Reset mid-RUN
    step(0, 1, 0, 0, 0, NONE);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, WR);
    step(1, 0, 0, 0, 0, WRRD);
    idle(3);
    chk("pre_reset_run", state, 2);
    rst = 1'b1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    chk("midrun_reset_state", state, 0);
    chk("midrun_reset_offset", offset, 64);
    chk("midrun_reset_outputs", int'({en, wr, rd, out_valid}), 0);
    sample_tick = 1'b0;
    rst = 1'b0;
    tick3(NONE);
    chk("post_reset_state", state, 0);

    idle(4);
    chk("pulse_queue_empty", exp_q.size(), 0);
    chk("out_valid_queue_empty", ov_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
